// File: rtl/ctrl_hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the 5-stage MIPS pipeline: D-stage stall plus D/E/M forwarding selects.
// Optional HAZARD_STALL_CNT_EN adds a free-running stall-cycle counter (stall_cnt).
module ctrl_hazard_scoreboard #(
  parameter int unsigned TNEW_W = 2
`ifdef HAZARD_STALL_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_D,
  input  logic [4:0]        rt_D,
  input  logic [TNEW_W-1:0] tuse_rs_D,
  input  logic [TNEW_W-1:0] tuse_rt_D,
  input  logic [4:0]        a3_D,
  input  logic              we_D,
  input  logic [TNEW_W-1:0] tnew_D,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              fwd_rt_M
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } e_stage_t;

  typedef struct packed {
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } m_stage_t;

  typedef struct packed {
    logic [REG_W-1:0] a3;
    logic             we;
  } w_stage_t;

  e_stage_t e_q, e_d;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;

  logic e_wr, m_wr, w_wr;

  // A producer matches a source only when it really writes a non-zero register.
  function automatic logic hit(input logic wr, input logic [REG_W-1:0] a3,
                               input logic [REG_W-1:0] src);
    return wr && (a3 == src) && (src != '0);
  endfunction

  // Nearest producer decides; a not-yet-ready nearest match blocks the farther one.
  function automatic logic [1:0] pick(input logic near_hit, input logic near_rdy,
                                      input logic far_hit, input logic far_rdy);
    logic [1:0] sel;
    sel = 2'b00;
    if (near_hit) begin
      if (near_rdy) sel = 2'b01;
    end else if (far_hit && far_rdy) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    e_wr = e_q.we && (e_q.a3 != '0);
    m_wr = m_q.we && (m_q.a3 != '0);
    w_wr = w_q.we && (w_q.a3 != '0);

    stall = (hit(e_wr, e_q.a3, rs_D) && (e_q.tnew > tuse_rs_D))
         || (hit(m_wr, m_q.a3, rs_D) && (m_q.tnew > tuse_rs_D))
         || (hit(e_wr, e_q.a3, rt_D) && (e_q.tnew > tuse_rt_D))
         || (hit(m_wr, m_q.a3, rt_D) && (m_q.tnew > tuse_rt_D));

    fwd_rs_D = pick(hit(e_wr, e_q.a3, rs_D), e_q.tnew == '0,
                    hit(m_wr, m_q.a3, rs_D), m_q.tnew == '0);
    fwd_rt_D = pick(hit(e_wr, e_q.a3, rt_D), e_q.tnew == '0,
                    hit(m_wr, m_q.a3, rt_D), m_q.tnew == '0);
    fwd_rs_E = pick(hit(m_wr, m_q.a3, e_q.rs), m_q.tnew == '0,
                    hit(w_wr, w_q.a3, e_q.rs), 1'b1);
    fwd_rt_E = pick(hit(m_wr, m_q.a3, e_q.rt), m_q.tnew == '0,
                    hit(w_wr, w_q.a3, e_q.rt), 1'b1);
    fwd_rt_M = hit(w_wr, w_q.a3, m_q.rt);
  end

  // Next pipeline shadow: bubble into E on stall, Tnew counts down toward 0.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs   = rs_D;
      e_d.rt   = rt_D;
      e_d.a3   = a3_D;
      e_d.we   = we_D;
      e_d.tnew = tnew_D;
    end
    m_d.rt   = e_q.rt;
    m_d.a3   = e_q.a3;
    m_d.we   = e_q.we;
    m_d.tnew = (e_q.tnew == '0) ? '0 : e_q.tnew - TNEW_W'(1);
    w_d.a3   = m_q.a3;
    w_d.we   = m_q.we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_hazard_scoreboard.sv
// Directed bench for ctrl_hazard_scoreboard: load-use, branch, jal/jr, $0, store and reset-mid-stall cases.
// Define HAZARD_STALL_CNT_EN to also check the stall counter.
module tb_ctrl_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       we_D;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic       fwd_rt_M;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp;
  int n_err;

  ctrl_hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .rs_D      (rs_D),
    .rt_D      (rt_D),
    .tuse_rs_D (tuse_rs_D),
    .tuse_rt_D (tuse_rt_D),
    .a3_D      (a3_D),
    .we_D      (we_D),
    .tnew_D    (tnew_D),
    .stall     (stall),
    .fwd_rs_D  (fwd_rs_D),
    .fwd_rt_D  (fwd_rt_D),
    .fwd_rs_E  (fwd_rs_E),
    .fwd_rt_E  (fwd_rt_E),
    .fwd_rt_M  (fwd_rt_M)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one D-stage instruction; outputs are checked 1 time unit later.
  task automatic drive(input int rs, input int rt, input int trs, input int trt,
                       input int a3, input int we, input int tnew);
    rs_D      = 5'(rs);
    rt_D      = 5'(rt);
    tuse_rs_D = 2'(trs);
    tuse_rt_D = 2'(trt);
    a3_D      = 5'(a3);
    we_D      = 1'(we);
    tnew_D    = 2'(tnew);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef HAZARD_STALL_CNT_EN
    chk(tag, stall_cnt, 32'(exp));
`else
    if (tag.len() == 0 || exp < 0) $display("unexpected counter check");
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    // Reset with a hazard-looking D instruction: zero state must give quiet outputs.
    drive(8, 9, 0, 0, 8, 1, 2);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd_rs_D", 32'(fwd_rs_D), 0);
    chk("rst_fwd_rt_E", 32'(fwd_rt_E), 0);
    chk("rst_fwd_rt_M", 32'(fwd_rt_M), 0);
    chk_cnt("rst_cnt", 0);
    drive(0, 0, 3, 3, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Case 1: lw $8 then addu rs=8 tuse=1.
    drive(0, 0, 3, 3, 8, 1, 2);
    chk("c1_lw_stall", 32'(stall), 0);
    tick();
    drive(8, 0, 1, 3, 10, 1, 1);
    chk("c1_stall", 32'(stall), 1);
    chk("c1_fwd_rs_D_e", 32'(fwd_rs_D), 0);
    tick();
    chk("c1_release", 32'(stall), 0);
    chk("c1_fwd_rs_D_m", 32'(fwd_rs_D), 0);
    chk_cnt("c1_cnt", 1);
    tick();
    drive(0, 0, 3, 3, 0, 0, 0);
    chk("c1_fwd_rs_E_w", 32'(fwd_rs_E), 2);

    // Case 2: addu $8 then beq rs=8 tuse=0.
    drive(0, 0, 3, 3, 8, 1, 1);
    chk("c2_addu_stall", 32'(stall), 0);
    tick();
    drive(8, 0, 0, 0, 0, 0, 0);
    chk("c2_stall", 32'(stall), 1);
    tick();
    chk("c2_release", 32'(stall), 0);
    chk("c2_fwd_rs_D", 32'(fwd_rs_D), 2);
    chk("c2_fwd_rt_D_r0", 32'(fwd_rt_D), 0);
    chk_cnt("c2_cnt", 2);

    // Case 3: jal then jr $31.
    drive(0, 0, 3, 3, 31, 1, 0);
    tick();
    drive(31, 0, 0, 3, 0, 0, 0);
    chk("c3_stall", 32'(stall), 0);
    chk("c3_fwd_rs_D", 32'(fwd_rs_D), 1);

    // Case 4: addu $0 (rs=31) then beq $0,$0.
    drive(31, 0, 1, 1, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("c4_stall", 32'(stall), 0);
    chk("c4_fwd_rs_D", 32'(fwd_rs_D), 0);
    chk("c4_fwd_rt_D", 32'(fwd_rt_D), 0);
    chk("c4_fwd_rs_E_m", 32'(fwd_rs_E), 1);
    chk("c4_fwd_rt_E", 32'(fwd_rt_E), 0);

    // Case 5: lw $9 then sw rt=9 tuse_rt=2.
    drive(0, 0, 3, 3, 9, 1, 2);
    tick();
    drive(0, 9, 1, 2, 0, 0, 0);
    chk("c5_stall", 32'(stall), 0);
    chk("c5_fwd_rt_D", 32'(fwd_rt_D), 0);
    tick();
    drive(0, 0, 3, 3, 0, 0, 0);
    chk("c5_fwd_rt_E_block", 32'(fwd_rt_E), 0);
    tick();
    chk("c5_fwd_rt_M", 32'(fwd_rt_M), 1);

    // rs and rt hazards on different stages give one stall; tuse=3 never stalls.
    drive(0, 0, 3, 3, 5, 1, 2);
    tick();
    drive(0, 0, 3, 3, 6, 1, 1);
    tick();
    drive(6, 5, 3, 3, 0, 0, 0);
    chk("dual_tuse3", 32'(stall), 0);
    drive(5, 6, 0, 0, 0, 0, 0);
    chk("dual_stall", 32'(stall), 1);
    tick();
    chk("dual_release", 32'(stall), 0);
    chk("dual_fwd_rs_D", 32'(fwd_rs_D), 0);
    chk("dual_fwd_rt_D", 32'(fwd_rt_D), 2);

    // lw then beq tuse=0: two stall cycles.
    drive(0, 0, 3, 3, 7, 1, 2);
    tick();
    drive(7, 0, 0, 0, 0, 0, 0);
    chk("lu2_stall_e", 32'(stall), 1);
    tick();
    chk("lu2_stall_m", 32'(stall), 1);
    tick();
    chk("lu2_release", 32'(stall), 0);
    chk("lu2_fwd_rs_D", 32'(fwd_rs_D), 0);
    chk_cnt("lu2_cnt", 5);

    // Case 6: reset during a stall.
    drive(0, 0, 3, 3, 8, 1, 2);
    tick();
    drive(8, 0, 0, 0, 0, 0, 0);
    chk("c6_stall", 32'(stall), 1);
    reset = 1'b1;
    #1;
    chk("c6_rst_stall", 32'(stall), 0);
    chk("c6_rst_fwd_rs_D", 32'(fwd_rs_D), 0);
    chk("c6_rst_fwd_rs_E", 32'(fwd_rs_E), 0);
    chk_cnt("c6_rst_cnt", 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 3, 3, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
